uart_tx_arbiter: RTL

Shares a single `uart_tx` byte transmitter among N requesters, such as cipher output, status/echo messages and debug dumps. Arbitration is round-robin per byte. The block sequences the transmitter's `activate`/`active`/`done` handshake so that requesters only see a simple req/ack byte interface. An optional packet lock keeps a requester's multi-byte message contiguous on the line.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/uart_tx_arbiter_if.sv | 41 ++++
 rtl/uart_tx_arbiter_rr_picker.sv | 41 ++++
 rtl/uart_tx_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx round-robin arbiter.
// CLKS_PER_BIT records the 115200 baud divider at 50 MHz; the RTL itself is baud-agnostic.
package uart_arb_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int CNT_W_DEF    = 16;
    localparam int CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        ST_SYNC      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_ISSUE     = 3'd2,
        ST_WAIT_ACT  = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_WAIT_CLR  = 3'd5
    } arb_state_t;

    // Width of a requester index; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte bus plus the uart_tx activate/active/done handshake.
// slave = arbiter side, master = requesters and transmitter side.
interface uart_tx_arbiter_if
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   ack;

    logic               uart_activate;
    logic [7:0]         uart_data;
    logic               uart_active;
    logic               uart_done;

    modport slave (
        input  req,
        input  req_data,
        input  req_last,
        output ack,
        output uart_activate,
        output uart_data,
        input  uart_active,
        input  uart_done
    );

    modport master (
        output req,
        output req_data,
        output req_last,
        input  ack,
        input  uart_activate,
        input  uart_data,
        output uart_active,
        output uart_done
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: search starts one past i_ptr and wraps.
// When i_lock_en is set only requester i_lock_id is eligible.
module rr_picker
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_lock_en,
    input  logic [IDX_W-1:0] i_lock_id,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [N_REQ-1:0] w_masked;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
        assign w_masked[gi] = i_req[gi] & (~i_lock_en | (i_lock_id == IDX_W'(gi)));
    end

    // Walk offsets from farthest to nearest so the nearest candidate wins.
    always_comb begin
        int w_cand;
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_cand = int'(i_ptr) + k;
            if (w_cand >= N_REQ) begin
                w_cand = w_cand - N_REQ;
            end
            if (w_masked[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin per-byte arbiter sharing one uart_tx among N_REQ requesters.
// Define UART_ARB_PKT_LOCK_EN to keep multi-byte packets (req_last) contiguous.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    uart_tx_arbiter_if.slave            bus,
    output logic [idx_width(N_REQ)-1:0] grant_id,
    output logic                        busy,
    output logic [CNT_W-1:0]            sent_count
);

    localparam int IDX_W = idx_width(N_REQ);

    arb_state_t       r_state;
    arb_state_t       w_state_next;

    logic [N_REQ-1:0] r_ack;
    logic             r_activate;
    logic [7:0]       r_data;
    logic [IDX_W-1:0] r_grant_id;
    logic [CNT_W-1:0] r_sent_count;

    logic             w_grant;
    logic             w_count_inc;
    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic [7:0]       w_pick_byte;
    logic [N_REQ-1:0] w_ack_next;
    logic             w_lock_en;
    logic [IDX_W-1:0] w_lock_id;

    rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req     (bus.req),
        .i_ptr     (r_grant_id),
        .i_lock_en (w_lock_en),
        .i_lock_id (w_lock_id),
        .o_valid   (w_pick_valid),
        .o_idx     (w_pick_idx)
    );

    assign w_pick_byte = bus.req_data[{w_pick_idx, 3'b000} +: 8];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ack
        assign w_ack_next[gi] = w_grant & (w_pick_idx == IDX_W'(gi));
    end

`ifdef UART_ARB_PKT_LOCK_EN
    logic             r_lock_valid;
    logic [IDX_W-1:0] r_lock_id;

    // A granted non-final byte pins the picker to that requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_valid <= 1'b0;
            r_lock_id    <= '0;
        end else if (w_grant) begin
            r_lock_valid <= ~bus.req_last[w_pick_idx];
            r_lock_id    <= w_pick_idx;
        end
    end

    assign w_lock_en = r_lock_valid;
    assign w_lock_id = r_lock_id;
`else
    logic w_unused_last;

    assign w_lock_en     = 1'b0;
    assign w_lock_id     = '0;
    assign w_unused_last = ^bus.req_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // SYNC exists because uart_tx has no reset and may still be mid-frame.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_count_inc  = 1'b0;
        case (r_state)
            ST_SYNC: begin
                if (!bus.uart_active && !bus.uart_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT_ACT;
            end
            ST_WAIT_ACT: begin
                if (bus.uart_active) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (bus.uart_done) begin
                    w_count_inc  = 1'b1;
                    w_state_next = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                // done lasts two cycles; wait it out so it is counted once.
                if (!bus.uart_done) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_SYNC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack        <= '0;
            r_activate   <= 1'b0;
            r_data       <= '0;
            r_grant_id   <= IDX_W'(N_REQ - 1);
            r_sent_count <= '0;
        end else begin
            r_ack      <= w_ack_next;
            r_activate <= w_grant;
            if (w_grant) begin
                r_data     <= w_pick_byte;
                r_grant_id <= w_pick_idx;
            end
            if (w_count_inc) begin
                r_sent_count <= r_sent_count + 1'b1;
            end
        end
    end

    assign bus.ack           = r_ack;
    assign bus.uart_activate = r_activate;
    assign bus.uart_data     = r_data;
    assign grant_id          = r_grant_id;
    assign busy              = (r_state != ST_IDLE);
    assign sent_count        = r_sent_count;

endmodule
